// File: rtl/toeplitz_seq_ctrl.sv
// Job-level sequencer for the Toeplitz hash datapath: seed load, then one
// shift/accumulate handshake pair per row, with abort and per-wait timeout.
module toeplitz_seq_ctrl #(
    parameter int unsigned N_ROWS  = 4096,
    parameter int unsigned ROW_W   = 12,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_ready,
    input  logic             shift_ack,
    input  logic             sum_ack,
    output logic             load_req,
    output logic             shift_en,
    output logic             sum_en,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             done,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SUM,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [TO_W-1:0]   tcnt, tcnt_nx;
    logic [ROW_W-1:0]  row_nx;
    logic              load_nx, shift_nx, sum_nx, busy_nx, done_nx, err_nx;
    logic              timed_out;

    assign timed_out = (tcnt == TO_LAST);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            row_idx     <= '0;
            load_req    <= 1'b0;
            shift_en    <= 1'b0;
            sum_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            tcnt        <= tcnt_nx;
            row_idx     <= row_nx;
            load_req    <= load_nx;
            shift_en    <= shift_nx;
            sum_en      <= sum_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            err_timeout <= err_nx;
        end
    end

    // Outputs are the registered image of the next state, so every strobe
    // appears the cycle after the input that caused it was sampled.
    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        row_nx   = row_idx;
        load_nx  = 1'b0;
        shift_nx = 1'b0;
        sum_nx   = 1'b0;
        busy_nx  = busy;
        done_nx  = 1'b0;
        err_nx   = 1'b0;

        if (state != S_IDLE && abort) begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    busy_nx = 1'b0;
                    if (start) begin
                        state_nx = S_LOAD;
                        load_nx  = 1'b1;
                        busy_nx  = 1'b1;
                        row_nx   = '0;
                        tcnt_nx  = '0;
                    end
                end
                S_LOAD: begin
                    if (timed_out) begin
                        state_nx = S_IDLE;
                        busy_nx  = 1'b0;
                        err_nx   = 1'b1;
                    end else if (seed_ready) begin
                        state_nx = S_SHIFT;
                        shift_nx = 1'b1;
                        tcnt_nx  = '0;
                    end else begin
                        load_nx  = 1'b1;
                        tcnt_nx  = tcnt + TO_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (timed_out) begin
                        state_nx = S_IDLE;
                        busy_nx  = 1'b0;
                        err_nx   = 1'b1;
                    end else if (shift_ack) begin
                        state_nx = S_SUM;
                        sum_nx   = 1'b1;
                        tcnt_nx  = '0;
                    end else begin
                        shift_nx = 1'b1;
                        tcnt_nx  = tcnt + TO_W'(1);
                    end
                end
                S_SUM: begin
                    if (timed_out) begin
                        state_nx = S_IDLE;
                        busy_nx  = 1'b0;
                        err_nx   = 1'b1;
                    end else if (sum_ack) begin
                        state_nx = S_NEXT;
                    end else begin
                        tcnt_nx  = tcnt + TO_W'(1);
                    end
                end
                S_NEXT: begin
                    if (row_idx == LAST_ROW) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                    end else begin
                        state_nx = S_SHIFT;
                        row_nx   = row_idx + ROW_W'(1);
                        shift_nx = 1'b1;
                        tcnt_nx  = '0;
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                    busy_nx  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toeplitz_seq_ctrl.sv
// Randomized bench: a responder answers handshakes from per-job delay plans,
// a timeline model predicts output events, and a monitor scores them.
module tb_toeplitz_seq_ctrl;

    localparam int N     = 4;
    localparam int RW    = 3;
    localparam int TO    = 32;
    localparam int TW    = 5;
    localparam int MAXJ  = 32;
    localparam int NEVER = 1000;
    localparam int TMAX  = TO - 2;

    localparam int K_L  = 0;
    localparam int K_LF = 1;
    localparam int K_S  = 2;
    localparam int K_SF = 3;
    localparam int K_A  = 4;
    localparam int K_D  = 5;
    localparam int K_E  = 6;
    localparam int K_B  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic seed_ready = 1'b0;
    logic shift_ack = 1'b0;
    logic sum_ack = 1'b0;
    logic load_req, shift_en, sum_en, busy, done, err_timeout;
    logic [RW-1:0] row_idx;

    toeplitz_seq_ctrl #(
        .N_ROWS (N),
        .ROW_W  (RW),
        .TIMEOUT(TO),
        .TO_W   (TW)
    ) dut (
        .clk_in     (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .seed_ready (seed_ready),
        .shift_ack  (shift_ack),
        .sum_ack    (sum_ack),
        .load_req   (load_req),
        .shift_en   (shift_en),
        .sum_en     (sum_en),
        .row_idx    (row_idx),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout)
    );

    typedef struct {
        int kind;
        int cyc;
        int row;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    int  nxt = 0;

    int p_seed [MAXJ];
    int p_abph [MAXJ];
    int p_abrow[MAXJ];
    int p_spur [MAXJ];
    int p_shift[MAXJ][N];
    int p_sum  [MAXJ][N];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input int c, input int r);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.row  = r;
        exp_q.push_back(e);
    endtask

    // Timeline of one job from its first load_req cycle L, derived from the
    // handshake delays: every accepted ack costs delay+1 cycles, NEXT costs 1.
    task automatic model_job(input int j, input int L, output int te, output bit fin);
        int t, d;
        fin = 1'b0;
        push_ev(K_L, L, 0);
        d = p_seed[j];
        if (d > TMAX) begin
            te = L + TO;
            push_ev(K_LF, te, 0); push_ev(K_E, te, 0); push_ev(K_B, te, 0);
            return;
        end
        if (p_abph[j] == 1) begin
            te = L + d + 1;
            push_ev(K_LF, te, 0); push_ev(K_B, te, 0);
            return;
        end
        t = L + d + 1;
        push_ev(K_LF, t, 0);
        for (int r = 0; r < N; r++) begin
            push_ev(K_S, t, r);
            d = p_shift[j][r];
            if (d > TMAX) begin
                te = t + TO;
                push_ev(K_SF, te, r); push_ev(K_E, te, r); push_ev(K_B, te, r);
                return;
            end
            if (p_abph[j] == 2 && p_abrow[j] == r) begin
                te = t + d + 1;
                push_ev(K_SF, te, r); push_ev(K_B, te, r);
                return;
            end
            t = t + d + 1;
            push_ev(K_SF, t, r);
            push_ev(K_A, t, r);
            d = p_sum[j][r];
            if (d > TMAX) begin
                te = t + TO;
                push_ev(K_E, te, r); push_ev(K_B, te, r);
                return;
            end
            if (p_abph[j] == 3 && p_abrow[j] == r) begin
                te = t + d + 1;
                push_ev(K_B, te, r);
                return;
            end
            t = t + d + 2;
        end
        push_ev(K_D, t, N - 1);
        push_ev(K_B, t, N - 1);
        te  = t;
        fin = 1'b1;
    endtask

    task automatic set_plan(input int j, input int d);
        p_seed[j] = d;
        for (int r = 0; r < N; r++) begin
            p_shift[j][r] = d;
            p_sum[j][r]   = d;
        end
        p_abph[j]  = 0;
        p_abrow[j] = 0;
        p_spur[j]  = 0;
    endtask

    task automatic rand_plan(input int j, input int maxd);
        set_plan(j, 0);
        p_seed[j] = int'($urandom_range(0, maxd));
        for (int r = 0; r < N; r++) begin
            p_shift[j][r] = int'($urandom_range(0, maxd));
            p_sum[j][r]   = int'($urandom_range(0, maxd));
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input int j, output int L, output int te, output bit fin);
        wait_until(nxt);
        start = 1'b1;
        L = cyc + 1;
        model_job(j, L, te, fin);
        wait_until(L);
        start = 1'b0;
        nxt = (fin ? te + 1 : te) + int'($urandom_range(0, 2));
    endtask

    // Responder: answers each handshake after the planned number of cycles,
    // optionally aborting on the ack cycle or driving acks nobody waits for.
    int rj, li, si, ui;
    bit pl, ps, sp;
    initial begin
        int j, r;
        rj = -1; li = 0; si = 0; ui = 0;
        pl = 1'b0; ps = 1'b0; sp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            seed_ready = 1'b0;
            shift_ack  = 1'b0;
            sum_ack    = 1'b0;
            abort      = 1'b0;
            if (!rst) begin
                pl = 1'b0; ps = 1'b0; sp = 1'b0;
            end else begin
                if (load_req) begin
                    if (!pl) begin
                        li = 0;
                        if (rj < MAXJ - 1) rj++;
                    end else li++;
                end
                pl = load_req;
                if (shift_en) begin
                    if (!ps) si = 0; else si++;
                end
                ps = shift_en;
                if (sum_en) begin
                    sp = 1'b1;
                    ui = 0;
                end else if (sp) ui++;
                if (!busy) sp = 1'b0;
                j = (rj < 0) ? 0 : rj;
                r = int'(row_idx);
                if (r > N - 1) r = N - 1;
                if (load_req && li == p_seed[j]) begin
                    seed_ready = 1'b1;
                    if (p_abph[j] == 1) abort = 1'b1;
                end
                if (shift_en) begin
                    if (si == p_shift[j][r]) begin
                        shift_ack = 1'b1;
                        if (p_abph[j] == 2 && p_abrow[j] == r) abort = 1'b1;
                    end else if (p_spur[j] != 0) begin
                        seed_ready = 1'b1;
                        sum_ack    = 1'b1;
                    end
                end
                if (sp) begin
                    if (ui == p_sum[j][r]) begin
                        sum_ack = 1'b1;
                        sp      = 1'b0;
                        if (p_abph[j] == 3 && p_abrow[j] == r) abort = 1'b1;
                    end else if (p_spur[j] != 0) begin
                        shift_ack  = 1'b1;
                        seed_ready = 1'b1;
                    end
                end
            end
        end
    end

    task automatic see(input int k);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_unexpected: got kind=%0d cyc=%0d row=%0d, expected no event",
                     k, cyc, row_idx);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.row != int'(row_idx)) begin
                bad++;
                $display("FAIL event: got kind=%0d cyc=%0d row=%0d, expected kind=%0d cyc=%0d row=%0d",
                         k, cyc, row_idx, e.kind, e.cyc, e.row);
            end
        end
    endtask

    bit ml, ms, mb;
    initial begin
        ml = 1'b0; ms = 1'b0; mb = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (load_req && !ml)  see(K_L);
                if (!load_req && ml)  see(K_LF);
                if (shift_en && !ms)  see(K_S);
                if (!shift_en && ms)  see(K_SF);
                if (sum_en)           see(K_A);
                if (done)             see(K_D);
                if (err_timeout)      see(K_E);
                if (!busy && mb)      see(K_B);
            end
            ml = load_req;
            ms = shift_en;
            mb = busy;
        end
    end

    initial begin
        int L, te, L2, x, y;
        bit fin;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_load_req", load_req, 0);
        chk("reset_shift_en", shift_en, 0);
        chk("reset_sum_en", sum_en, 0);
        chk("reset_row_idx", row_idx, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err_timeout", err_timeout, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        nxt = cyc + 1;

        set_plan(0, 0);
        start_job(0, L, te, fin);

        rand_plan(1, 3);
        p_seed[1] = 20;
        start_job(1, L, te, fin);

        rand_plan(2, 2);
        p_shift[2][2] = NEVER;
        start_job(2, L, te, fin);

        rand_plan(3, 3);
        start_job(3, L, te, fin);

        rand_plan(4, 3);
        p_abph[4]  = 3;
        p_abrow[4] = 1;
        start_job(4, L, te, fin);

        rand_plan(5, 2);
        start_job(5, L, te, fin);
        wait_until(te);
        start = 1'b1;
        wait_until(te + 1);
        start = 1'b0;
        nxt = te + 3;

        rand_plan(6, 3);
        p_spur[6] = 1;
        rand_plan(7, 2);
        wait_until(nxt);
        start = 1'b1;
        model_job(6, cyc + 1, te, fin);
        L2 = fin ? te + 2 : te + 1;
        model_job(7, L2, te, fin);
        wait_until(L2);
        start = 1'b0;
        nxt = fin ? te + 1 : te;

        rand_plan(8, 2);
        p_seed[8]   = TMAX;
        p_sum[8][0] = TMAX;
        start_job(8, L, te, fin);

        for (int j = 9; j < 19; j++) begin
            rand_plan(j, 4);
            p_spur[j] = int'($urandom_range(0, 1));
            x = int'($urandom_range(0, 9));
            if (x < 3) begin
                p_abph[j]  = int'($urandom_range(1, 3));
                p_abrow[j] = int'($urandom_range(0, N - 1));
            end else if (x < 5) begin
                y = int'($urandom_range(0, 2 * N));
                if (y == 0) p_seed[j] = NEVER;
                else if (y <= N) p_shift[j][y - 1] = NEVER;
                else p_sum[j][y - N - 1] = NEVER;
            end
            start_job(j, L, te, fin);
        end

        wait_until(nxt + 2);
        chk("events_pending_before_reset", exp_q.size(), 0);

        set_plan(19, 0);
        start_job(19, L, te, fin);
        wait_until(L + 10);
        #5;
        chk("pre_reset_shift_en", shift_en, 1);
        chk("pre_reset_row_idx", row_idx, 3);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("midjob_reset_load_req", load_req, 0);
        chk("midjob_reset_shift_en", shift_en, 0);
        chk("midjob_reset_sum_en", sum_en, 0);
        chk("midjob_reset_row_idx", row_idx, 0);
        chk("midjob_reset_busy", busy, 0);
        chk("midjob_reset_done", done, 0);
        chk("midjob_reset_err_timeout", err_timeout, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        nxt = cyc + 1;

        rand_plan(20, 3);
        start_job(20, L, te, fin);
        wait_until(nxt + 3);
        chk("events_pending_at_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toeplitz_seq_ctrl.md
Name: toeplitz_seq_ctrl

Overview:
Top-level sequencer for the Toeplitz hashing datapath. Starts a hash job and requests a full 7168-bit seed load from the ROM reader. Then steps the seed-shift unit one row at a time, issuing one accumulate strobe per row until N_ROWS rows are produced. Sits between the host/test logic and the read_rom / shift_seed / accumulator blocks; it owns all job-level handshakes, abort and timeout handling.

Parameters:
N_ROWS, 4096, rows (output hash bits) per job
ROW_W, 12, width of row_idx; must satisfy 2^ROW_W >= N_ROWS
TIMEOUT, 1024, max cycles any single handshake wait may last before error
TO_W, 10, width of timeout counter; 2^TO_W >= TIMEOUT

Ports:
clk_in  input  1  single clock, all logic rising-edge
rst  input  1  asynchronous, active-low reset
start  input  1  job request; sampled only in IDLE
abort  input  1  synchronous cancel; any state
seed_ready  input  1  ROM reader: full seed loaded (level or pulse)
shift_ack  input  1  shift unit: current row valid on shift_row
sum_ack  input  1  accumulator: row folded into result
load_req  output  1  request seed load from ROM reader
shift_en  output  1  request next shifted row
sum_en  output  1  one-cycle accumulate strobe
row_idx  output  ROW_W  index of row currently in flight
busy  output  1  job active
done  output  1  one-cycle job-complete pulse
err_timeout  output  1  one-cycle handshake-timeout pulse

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; row_idx=0; timeout counter 0.
- All outputs registered; each changes the cycle after the causing input is sampled.
- States: IDLE, LOAD, SHIFT, SUM, NEXT, DONE.
- IDLE: start=1 -> LOAD; next cycle load_req=1, busy=1, row_idx=0. start outside IDLE ignored.
- LOAD: load_req held 1 until seed_ready sampled 1 -> SHIFT; load_req=0, shift_en=1 next cycle.
- SHIFT: shift_en held 1 until shift_ack sampled 1 -> SUM; shift_en=0, sum_en=1 for exactly one cycle.
- SUM: wait for sum_ack; sum_ack may arrive in the same cycle sum_en is high. On sum_ack -> NEXT.
- NEXT, one cycle:
  - row_idx==N_ROWS-1 -> DONE.
  - Otherwise row_idx+1 -> SHIFT (shift_en=1 next cycle).
- DONE: done=1 for one cycle, busy=0, row_idx holds N_ROWS-1 -> IDLE. start sampled in DONE is ignored.
- Minimum latency:
  - start to load_req: 1 cycle.
  - Per row, with immediate acks: 3 cycles (SHIFT, SUM, NEXT).
- Acks outside their own wait state (e.g. shift_ack in SUM, seed_ready in SHIFT) are ignored. No buffering.
- Timeout: counter clears on entry to LOAD, SHIFT and SUM, and increments each waiting cycle. Reaching TIMEOUT-1 without the awaited ack:
  - err_timeout=1 for one cycle.
  - load_req/shift_en/sum_en=0, busy=0, state -> IDLE.
  - row_idx holds the failing row for diagnosis; done is not asserted.
- Abort: abort=1 in any non-IDLE state -> IDLE next cycle. All strobes 0, busy=0, no done, no err. row_idx holds.
- Priority: abort > timeout > ack. An ack in the same cycle as abort is discarded.
- Reset asserted mid-job: immediate return to reset values; the partial job is lost.
- row_idx never wraps: the increment happens only in NEXT with row_idx < N_ROWS-1.

Test Plan:
- N_ROWS=4; reset release, start pulse; responder acks each strobe in the same cycle -> load_req 1 cycle after start; rows 0..3 each get exactly one shift_en/sum_en; done pulses once at start+1+1+4*3 cycles; busy low after done.
- seed_ready delayed 20 cycles, TIMEOUT=1024 -> load_req stays high all 20 cycles; no shift_en before seed_ready; job completes normally.
- TIMEOUT=16, shift_ack never returned on row 2 -> err_timeout pulse exactly 16 cycles after SHIFT entry; row_idx=2; busy=0; no done; a new start then runs a full job.
- abort asserted together with sum_ack on row 1 -> next cycle IDLE; busy=0; no done; no further sum_en; row_idx=1.
- start held high continuously through a job, plus spurious shift_ack while in SUM -> only one job until DONE; spurious ack has no effect; a second job begins only after returning to IDLE.
- rst driven low while shift_en=1 on row 3 -> all outputs 0 immediately (asynchronous, before the next clock edge); row_idx=0.
